// File: rtl/aoc_day10_pkg.sv
// Shared defaults and FSM encoding for the button-combination solver blocks.
package aoc_day10_pkg;

  localparam int DEFAULT_BITS_PER_JOLTAGE = 9;
  localparam int DEFAULT_MACHINE_COUNT    = 10;
  localparam int DEFAULT_MAX_BUTTON_COUNT = 13;
  localparam int PRESS_W                  = $clog2(DEFAULT_MAX_BUTTON_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } enum_state_t;

endpackage

// File: rtl/combination_press_counter.sv
// Combinational press counting for one button combination: how many pressed
// buttons drive each counter, plus the total number of pressed buttons.
module combination_press_counter
  import aoc_day10_pkg::*;
#(
  parameter int MAX_BUTTON_COUNT = DEFAULT_MAX_BUTTON_COUNT,
  parameter int MACHINE_COUNT    = DEFAULT_MACHINE_COUNT,
  parameter int PW               = $clog2(MAX_BUTTON_COUNT + 1)
) (
  input  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] buttons,
  input  logic [MAX_BUTTON_COUNT-1:0]               combination,
  output logic [MACHINE_COUNT*PW-1:0]               presses,
  output logic [PW-1:0]                             press_count
);

  for (genvar gi = 0; gi < MACHINE_COUNT; gi++) begin : g_counter
    logic [PW-1:0] cnt;
    // Button j drives counter gi through bit j*MACHINE_COUNT+gi of the column.
    always_comb begin
      cnt = '0;
      for (int j = 0; j < MAX_BUTTON_COUNT; j++) begin
        cnt = cnt + PW'(buttons[j*MACHINE_COUNT+gi] & combination[j]);
      end
    end
    assign presses[gi*PW +: PW] = cnt;
  end

  // Popcount of the combination mask itself.
  always_comb begin
    press_count = '0;
    for (int j = 0; j < MAX_BUTTON_COUNT; j++) begin
      press_count = press_count + PW'(combination[j]);
    end
  end

endmodule

// File: rtl/combination_target_enumerator.sv
// Walks every button combination of a machine, drops those that overshoot a
// target (or leave an odd remainder when parity filtering is on) and streams
// the survivors with their halved remaining targets over valid/ready.
module combination_target_enumerator
  import aoc_day10_pkg::*;
#(
  parameter int MAX_BUTTON_COUNT = DEFAULT_MAX_BUTTON_COUNT,
  parameter int MACHINE_COUNT    = DEFAULT_MACHINE_COUNT,
  parameter int BITS_PER_JOLTAGE = DEFAULT_BITS_PER_JOLTAGE,
  parameter bit PARITY_FILTER    = 1'b1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]      button_count,
  input  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0]  flattened_buttons,
  input  logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]  flattened_target,
  output logic                                       busy,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [MAX_BUTTON_COUNT-1:0]                out_combination,
  output logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]      out_press_count,
  output logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]  out_new_target,
  output logic                                       done
);

  localparam int PW = $clog2(MAX_BUTTON_COUNT + 1);
  localparam int CW = MAX_BUTTON_COUNT + 1;
  localparam int BW = BITS_PER_JOLTAGE;
  localparam int TW = MACHINE_COUNT * BW;
  localparam int XW = (BW > PW) ? BW : PW;

  enum_state_t                              state_reg;
  logic [CW-1:0]                            comb_reg;
  logic [CW-1:0]                            last_reg;
  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] buttons_reg;
  logic [TW-1:0]                            target_reg;

  logic                                     s1_valid_reg;
  logic [MAX_BUTTON_COUNT-1:0]              s1_comb_reg;
  logic [MACHINE_COUNT*PW-1:0]              s1_presses_reg;
  logic [PW-1:0]                            s1_count_reg;

  logic [MACHINE_COUNT*PW-1:0]              presses_next;
  logic [PW-1:0]                            count_next;
  logic [MACHINE_COUNT-1:0]                 lane_reject;
  logic [TW-1:0]                            lane_new;
  logic                                     reject;
  logic                                     stall;
  logic [PW-1:0]                            bc_clamped;

  // A held survivor freezes everything upstream; rejected entries never hold.
  assign stall      = out_valid && !out_ready;
  assign bc_clamped = (button_count > PW'(MAX_BUTTON_COUNT)) ? PW'(MAX_BUTTON_COUNT) : button_count;

  combination_press_counter #(
    .MAX_BUTTON_COUNT(MAX_BUTTON_COUNT),
    .MACHINE_COUNT   (MACHINE_COUNT),
    .PW              (PW)
  ) u_press_counter (
    .buttons    (buttons_reg),
    .combination(comb_reg[MAX_BUTTON_COUNT-1:0]),
    .presses    (presses_next),
    .press_count(count_next)
  );

  // Per-lane overshoot/parity test and halved remainder, from the S1 registers.
  for (genvar gi = 0; gi < MACHINE_COUNT; gi++) begin : g_lane
    logic [XW-1:0] t_ext;
    logic [XW-1:0] p_ext;
    logic [BW-1:0] diff;
    assign t_ext = XW'(target_reg[gi*BW +: BW]);
    assign p_ext = XW'(s1_presses_reg[gi*PW +: PW]);
    assign diff  = target_reg[gi*BW +: BW] - p_ext[BW-1:0];
    assign lane_reject[gi]       = (t_ext < p_ext) || (PARITY_FILTER && diff[0]);
    assign lane_new[gi*BW +: BW] = {1'b0, diff[BW-1:1]};
  end

  assign reject = |lane_reject;

  // Control FSM: capture on start, step the counter, wait for the pipeline to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      comb_reg    <= '0;
      last_reg    <= '0;
      buttons_reg <= '0;
      target_reg  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            buttons_reg <= flattened_buttons;
            target_reg  <= flattened_target;
            comb_reg    <= '0;
            last_reg    <= (CW'(1) << bc_clamped) - CW'(1);
            busy        <= 1'b1;
            state_reg   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            if (comb_reg == last_reg) begin
              state_reg <= ST_DRAIN;
            end else begin
              comb_reg <= comb_reg + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!s1_valid_reg && (!out_valid || out_ready)) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // S1: register the issued combination with its press counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_comb_reg    <= '0;
      s1_presses_reg <= '0;
      s1_count_reg   <= '0;
    end else if (!stall) begin
      s1_valid_reg   <= (state_reg == ST_RUN);
      s1_comb_reg    <= comb_reg[MAX_BUTTON_COUNT-1:0];
      s1_presses_reg <= presses_next;
      s1_count_reg   <= count_next;
    end
  end

  // S2: present survivors; data fields only change when a new survivor lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_combination <= '0;
      out_press_count <= '0;
      out_new_target  <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid_reg && !reject;
      if (s1_valid_reg && !reject) begin
        out_combination <= s1_comb_reg;
        out_press_count <= s1_count_reg;
        out_new_target  <= lane_new;
      end
    end
  end

endmodule

// File: tb/tb_combination_target_enumerator.sv
// Directed bench: two small instances (parity filter on/off) and one full-width instance.
module tb_combination_target_enumerator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small instances share their inputs; each has its own ready.
  logic        start_s = 1'b0;
  logic [1:0]  bc_s    = '0;
  logic [3:0]  btn_s   = '0;
  logic [17:0] tgt_s   = '0;
  logic        rdy_a = 1'b1, rdy_b = 1'b1;
  logic        busy_a, vld_a, done_a, busy_b, vld_b, done_b;
  logic [1:0]  oc_a, op_a, oc_b, op_b;
  logic [17:0] nt_a, nt_b;

  // Full-width instance.
  logic         start_c = 1'b0;
  logic [3:0]   bc_c    = '0;
  logic [129:0] btn_c   = '0;
  logic [89:0]  tgt_c   = '0;
  logic         rdy_c   = 1'b1;
  logic         busy_c, vld_c, done_c;
  logic [12:0]  oc_c;
  logic [3:0]   op_c;
  logic [89:0]  nt_c;

  combination_target_enumerator #(.MAX_BUTTON_COUNT(2), .MACHINE_COUNT(2), .BITS_PER_JOLTAGE(9), .PARITY_FILTER(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_s), .button_count(bc_s), .flattened_buttons(btn_s),
    .flattened_target(tgt_s), .busy(busy_a), .out_valid(vld_a), .out_ready(rdy_a),
    .out_combination(oc_a), .out_press_count(op_a), .out_new_target(nt_a), .done(done_a));

  combination_target_enumerator #(.MAX_BUTTON_COUNT(2), .MACHINE_COUNT(2), .BITS_PER_JOLTAGE(9), .PARITY_FILTER(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_s), .button_count(bc_s), .flattened_buttons(btn_s),
    .flattened_target(tgt_s), .busy(busy_b), .out_valid(vld_b), .out_ready(rdy_b),
    .out_combination(oc_b), .out_press_count(op_b), .out_new_target(nt_b), .done(done_b));

  combination_target_enumerator #(.MAX_BUTTON_COUNT(13), .MACHINE_COUNT(10), .BITS_PER_JOLTAGE(9), .PARITY_FILTER(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .button_count(bc_c), .flattened_buttons(btn_c),
    .flattened_target(tgt_c), .busy(busy_c), .out_valid(vld_c), .out_ready(rdy_c),
    .out_combination(oc_c), .out_press_count(op_c), .out_new_target(nt_c), .done(done_c));

  typedef struct packed {
    logic [1:0]  comb;
    logic [1:0]  press;
    logic [17:0] nt;
  } small_txn_t;

  small_txn_t cur_a, cur_b;
  assign cur_a = {oc_a, op_a, nt_a};
  assign cur_b = {oc_b, op_b, nt_b};

  small_txn_t qa[$], qb[$], exp_a[$], exp_b[$];
  int done_cyc_a, done_cyc_b, done_cnt_a, done_cnt_b, lat_b;
  int c_count, c_bad, c_done_cnt, c_done_cyc;
  logic [12:0] c_last_comb;
  logic [3:0]  c_last_press;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Run both small instances from one start; rand_rdy toggles both readies randomly.
  task automatic run_small(input bit rand_rdy, input int exp_done);
    bit hold_a, hold_b;
    small_txn_t held_a, held_b;
    qa.delete(); qb.delete();
    done_cyc_a = -1; done_cyc_b = -1; done_cnt_a = 0; done_cnt_b = 0; lat_b = -1;
    hold_a = 1'b0; hold_b = 1'b0; held_a = '0; held_b = '0;
    rdy_a = 1'b1; rdy_b = 1'b1;
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (cyc == 1) begin
        check("a_busy_after_start", busy_a, 1'b1);
        check("b_busy_after_start", busy_b, 1'b1);
      end
      if (hold_a) begin
        check("a_stall_valid", vld_a, 1'b1);
        check("a_stall_data", cur_a, held_a);
      end
      if (hold_b) begin
        check("b_stall_valid", vld_b, 1'b1);
        check("b_stall_data", cur_b, held_b);
      end
      if (vld_b && lat_b < 0) lat_b = cyc;
      if (done_a) begin
        done_cnt_a++;
        if (done_cyc_a < 0) done_cyc_a = cyc;
        check("a_busy_at_done", busy_a, 1'b0);
      end
      if (done_b) begin
        done_cnt_b++;
        if (done_cyc_b < 0) done_cyc_b = cyc;
        check("b_busy_at_done", busy_b, 1'b0);
      end
      rdy_a = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      rdy_b = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vld_a && rdy_a) begin
        qa.push_back(cur_a);
        $display("txn A comb=%b press=%0d nt=(%0d,%0d)", oc_a, op_a, nt_a[8:0], nt_a[17:9]);
      end
      if (vld_b && rdy_b) begin
        qb.push_back(cur_b);
        $display("txn B comb=%b press=%0d nt=(%0d,%0d)", oc_b, op_b, nt_b[8:0], nt_b[17:9]);
      end
      hold_a = vld_a && !rdy_a; held_a = cur_a;
      hold_b = vld_b && !rdy_b; held_b = cur_b;
    end
    rdy_a = 1'b1; rdy_b = 1'b1;
    check("a_done_pulses", done_cnt_a, 1);
    check("b_done_pulses", done_cnt_b, 1);
    if (exp_done > 0) begin
      check("a_done_cycle", done_cyc_a, exp_done);
      check("b_done_cycle", done_cyc_b, exp_done);
    end
  endtask

  task automatic verify_small(input string tag);
    check($sformatf("%s_a_count", tag), qa.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < qa.size(); i++)
      check($sformatf("%s_a_txn%0d", tag, i), qa[i], exp_a[i]);
    check($sformatf("%s_b_count", tag), qb.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < qb.size(); i++)
      check($sformatf("%s_b_txn%0d", tag, i), qb[i], exp_b[i]);
  endtask

  // Run the wide instance to completion; optionally pulse start again mid-run
  // with a changed live target that must not be picked up.
  task automatic run_c(input int budget, input int restart_at);
    c_count = 0; c_bad = 0; c_done_cnt = 0; c_done_cyc = -1;
    c_last_comb = '0; c_last_press = '0;
    start_c = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start_c = (cyc == restart_at);
      if (cyc == restart_at) tgt_c = 90'd1;
      if (vld_c) begin
        if (oc_c !== 13'(c_count) || op_c !== 4'($countones(13'(c_count))) || nt_c !== '0) c_bad++;
        $display("txn C comb=%h press=%0d", oc_c, op_c);
        c_last_comb = oc_c; c_last_press = op_c;
        c_count++;
      end
      if (done_c) begin
        c_done_cnt++;
        if (c_done_cyc < 0) c_done_cyc = cyc;
      end
      if (c_done_cyc > 0 && cyc >= c_done_cyc + 3) break;
    end
    start_c = 1'b0;
    tgt_c = '0;
  endtask

  initial begin
    // Reset state, observed while reset is still asserted and after release.
    repeat (3) @(negedge clk);
    check("rst_a_outputs", {busy_a, vld_a, done_a, oc_a, op_a, nt_a}, '0);
    check("rst_b_outputs", {busy_b, vld_b, done_b, oc_b, op_b, nt_b}, '0);
    check("rst_c_ctrl", {busy_c, vld_c, done_c, oc_c, op_c}, '0);
    check("rst_c_target", |nt_c, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_a_busy", busy_a, 1'b0);

    // b0 drives c0,c1; b1 drives c0; target c0=3, c1=1.
    btn_s = 4'b0111; tgt_s = {9'd1, 9'd3}; bc_s = 2'd2;
    exp_a = '{'{2'b01, 2'd1, {9'd0, 9'd1}}};
    exp_b = '{'{2'b00, 2'd0, {9'd0, 9'd1}}, '{2'b01, 2'd1, {9'd0, 9'd1}},
              '{2'b10, 2'd1, {9'd0, 9'd1}}, '{2'b11, 2'd2, {9'd0, 9'd0}}};
    run_small(1'b0, 7);
    verify_small("basic");
    check("b_first_latency", lat_b, 3);

    // Same vectors under random backpressure must produce the same sequence.
    run_small(1'b1, -1);
    verify_small("bp1");
    run_small(1'b1, -1);
    verify_small("bp2");

    // Zero target: only combination 0 survives, combination 1 overshoots.
    btn_s = 4'b0001; tgt_s = '0; bc_s = 2'd1;
    exp_a = '{'{2'b00, 2'd0, 18'd0}};
    exp_b = '{'{2'b00, 2'd0, 18'd0}};
    run_small(1'b0, 5);
    verify_small("negative");

    // No buttons: only combination 0, rejected only by parity.
    btn_s = 4'b0111; tgt_s = {9'd1, 9'd3}; bc_s = 2'd0;
    exp_a = '{};
    exp_b = '{'{2'b00, 2'd0, {9'd0, 9'd1}}};
    run_small(1'b0, 4);
    verify_small("zero_buttons");

    // Full width: 13 unconnected buttons, zero target -> every combination survives.
    btn_c = '0; tgt_c = '0; bc_c = 4'd13; rdy_c = 1'b1;
    @(negedge clk);
    run_c(8400, -1);
    check("c_full_count", c_count, 8192);
    check("c_full_order", c_bad, 0);
    check("c_full_last_comb", c_last_comb, 13'h1FFF);
    check("c_full_last_press", c_last_press, 4'd13);
    check("c_full_done_pulses", c_done_cnt, 1);
    check("c_full_done_cycle", c_done_cyc, 8195);
    check("c_full_busy_end", busy_c, 1'b0);

    // Asynchronous reset mid-run.
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    repeat (29) @(negedge clk);
    check("c_mid_valid_before", vld_c, 1'b1);
    check("c_mid_busy_before", busy_c, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("c_mid_rst_valid", vld_c, 1'b0);
    check("c_mid_rst_busy", busy_c, 1'b0);
    check("c_mid_rst_comb", oc_c, 13'h0);
    @(negedge clk);
    check("c_mid_rst_done", done_c, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("c_mid_rst_done_after", done_c, 1'b0);

    // Replay from combination 0 with 3 buttons; a second start mid-run is ignored.
    bc_c = 4'd3;
    run_c(200, 4);
    check("c_replay_count", c_count, 8);
    check("c_replay_order", c_bad, 0);
    check("c_replay_last_comb", c_last_comb, 13'h0007);
    check("c_replay_done_pulses", c_done_cnt, 1);
    check("c_replay_done_cycle", c_done_cyc, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
